// File: rtl/serial_uart_bridge_pkg.sv
// Shared definitions for serial_uart_bridge: UART FSM state encoding and 8N1 frame constants.
// The optional parity bit (SERIAL_UART_PARITY_EN) uses the even_parity helper below.
package serial_uart_bridge_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_uart_bridge_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only alongside a pop.
// o_data reads as zero while empty so the processor never sees stale storage.
module serial_uart_bridge_byte_fifo
  import serial_uart_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Processor byte port <-> 8N1 UART bridge with a FIFO on each direction.
// Define SERIAL_UART_PARITY_EN to add an even-parity bit and the parity_err flag.
module serial_uart_bridge
  import serial_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] proc_tx_data,
  input  logic                 proc_tx_wren,
  output logic                 proc_tx_ready,
  output logic [DATA_BITS-1:0] proc_rx_data,
  output logic                 proc_rx_valid,
  input  logic                 proc_rx_rden,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic                 err_clear,
  output logic                 overrun_err,
  output logic                 frame_err
`ifdef SERIAL_UART_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_full, w_tx_empty, w_tx_pop;
  logic                 w_rx_full, w_rx_empty, w_rx_push;

  uart_state_e          r_tx_state, w_tx_next;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 w_tx_bit_done;

  uart_state_e          r_rx_state, w_rx_next;
  logic                 r_rx_sync1, r_rx_sync2, w_rx_line;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_wait;
  logic                 w_rx_half, w_rx_sample, w_rx_stop_ok;
  logic                 w_frame_set, w_overrun_set;
`ifdef SERIAL_UART_PARITY_EN
  logic                 r_tx_parity, r_rx_par_bad, w_parity_set;
`endif

  serial_uart_bridge_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(clock), .i_rst(reset), .i_push(proc_tx_wren), .i_data(proc_tx_data),
    .i_pop(w_tx_pop), .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  serial_uart_bridge_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(clock), .i_rst(reset), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(proc_rx_rden), .o_data(proc_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign proc_tx_ready = !w_tx_full;
  assign proc_rx_valid = !w_rx_empty;

  // ---------------- TX serializer ----------------
  assign w_tx_bit_done = (r_tx_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) r_tx_state <= UART_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      UART_IDLE:   if (!w_tx_empty) w_tx_next = UART_START;
      UART_START:  if (w_tx_bit_done) w_tx_next = UART_DATA;
      UART_DATA:
        if (w_tx_bit_done && r_tx_bit == BIT_LAST) begin
`ifdef SERIAL_UART_PARITY_EN
          w_tx_next = UART_PARITY;
`else
          w_tx_next = UART_STOP;
`endif
        end
      UART_PARITY: if (w_tx_bit_done) w_tx_next = UART_STOP;
      UART_STOP:   if (w_tx_bit_done) w_tx_next = UART_IDLE;
      default:     w_tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    uart_tx  = STOP_LEVEL;
    case (r_tx_state)
      UART_IDLE:  w_tx_pop = !w_tx_empty;
      UART_START: uart_tx = START_LEVEL;
      UART_DATA:  uart_tx = r_tx_shift[0];
      UART_PARITY: begin
`ifdef SERIAL_UART_PARITY_EN
        uart_tx = r_tx_parity;
`endif
      end
      default:    uart_tx = STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
`ifdef SERIAL_UART_PARITY_EN
      r_tx_parity <= 1'b0;
`endif
    end else if (r_tx_state == UART_IDLE) begin
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      if (w_tx_pop) begin
        r_tx_shift <= w_tx_head;
`ifdef SERIAL_UART_PARITY_EN
        r_tx_parity <= even_parity(w_tx_head);
`endif
      end
    end else if (w_tx_bit_done) begin
      r_tx_cnt <= '0;
      if (r_tx_state == UART_DATA) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  // ---------------- RX deserializer ----------------
  assign w_rx_line   = r_rx_sync2;
  assign w_rx_half   = (r_rx_cnt == CNT_HALF);
  assign w_rx_sample = (r_rx_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) r_rx_state <= UART_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      UART_IDLE:   if (w_rx_line == START_LEVEL) w_rx_next = UART_START;
      UART_START:  if (w_rx_half) w_rx_next = (w_rx_line == START_LEVEL) ? UART_DATA : UART_IDLE;
      UART_DATA:
        if (w_rx_sample && r_rx_bit == BIT_LAST) begin
`ifdef SERIAL_UART_PARITY_EN
          w_rx_next = UART_PARITY;
`else
          w_rx_next = UART_STOP;
`endif
        end
      UART_PARITY: if (w_rx_sample) w_rx_next = UART_STOP;
      UART_STOP: begin
        // After a bad stop bit, hold here until the line returns to idle.
        if (r_rx_wait) begin
          if (w_rx_line == STOP_LEVEL) w_rx_next = UART_IDLE;
        end else if (w_rx_sample && w_rx_line == STOP_LEVEL) begin
          w_rx_next = UART_IDLE;
        end
      end
      default:     w_rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    w_rx_stop_ok  = (r_rx_state == UART_STOP) && !r_rx_wait && w_rx_sample &&
                    (w_rx_line == STOP_LEVEL);
    w_frame_set   = (r_rx_state == UART_STOP) && !r_rx_wait && w_rx_sample &&
                    (w_rx_line != STOP_LEVEL);
`ifdef SERIAL_UART_PARITY_EN
    w_rx_push     = w_rx_stop_ok && !r_rx_par_bad;
    w_parity_set  = w_rx_stop_ok && r_rx_par_bad;
`else
    w_rx_push     = w_rx_stop_ok;
`endif
    w_overrun_set = w_rx_push && w_rx_full && !proc_rx_rden;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rx;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_wait  <= 1'b0;
`ifdef SERIAL_UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
`endif
    end else if (r_rx_state == UART_IDLE) begin
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_wait <= 1'b0;
`ifdef SERIAL_UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
`endif
    end else if (r_rx_state == UART_START) begin
      r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
    end else begin
      r_rx_cnt <= w_rx_sample ? '0 : r_rx_cnt + 1'b1;
      if (w_rx_sample) begin
        if (r_rx_state == UART_DATA) begin
          r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
          r_rx_bit   <= r_rx_bit + 1'b1;
        end
`ifdef SERIAL_UART_PARITY_EN
        if (r_rx_state == UART_PARITY) r_rx_par_bad <= (w_rx_line != even_parity(r_rx_shift));
`endif
        if (r_rx_state == UART_STOP && w_rx_line != STOP_LEVEL) r_rx_wait <= 1'b1;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as err_clear keeps the flag high.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_err <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SERIAL_UART_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      overrun_err <= w_overrun_set | (overrun_err & !err_clear);
      frame_err   <= w_frame_set   | (frame_err & !err_clear);
`ifdef SERIAL_UART_PARITY_EN
      parity_err  <= w_parity_set  | (parity_err & !err_clear);
`endif
    end
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Sits directly on the processor's byte-wide serial port and converts it to an asynchronous 8N1 UART line pair.
- TX path: processor bytes → FIFO → serializer. RX path: deserializer → FIFO → processor.
- Connects one-to-one to the processor signals: serial_in, serial_valid_in, serial_ready_in, serial_rden_out, serial_out, serial_wren_out.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; even, ≥4.
- FIFO_DEPTH, 4: entries per FIFO; power of 2, ≥2.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- proc_tx_data  in  8  byte from processor (connects to serial_out).
- proc_tx_wren  in  1  write strobe (connects to serial_wren_out).
- proc_tx_ready  out  1  TX FIFO not full (connects to serial_ready_in).
- proc_rx_data  out  8  RX FIFO head (connects to serial_in).
- proc_rx_valid  out  1  RX FIFO not empty (connects to serial_valid_in).
- proc_rx_rden  in  1  pop strobe (connects to serial_rden_out).
- uart_rx  in  1  asynchronous serial input line.
- uart_tx  out  1  serial output line, idle high.
- err_clear  in  1  clears the sticky error flags.
- overrun_err  out  1  sticky: RX byte dropped because the FIFO was full.
- frame_err  out  1  sticky: stop bit sampled as 0.

Behaviour:
- Reset values:
  - uart_tx=1, proc_tx_ready=1, proc_rx_valid=0, proc_rx_data=0.
  - Both error flags 0, both FIFOs empty, both FSMs in IDLE.
  - RX synchronizer flops reset to 1.
- Reset mid-frame aborts the frame. uart_tx is high the cycle after reset is sampled.
- FIFOs:
  - First-word fall-through.
  - A push is accepted when not full, or when full with a pop in the same cycle.
  - A pop when empty is ignored.
  - A wren while proc_tx_ready=0 is ignored; the byte is lost.
  - Occupancy counter uses log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty: pop the head into the shift register, and enter START on the next cycle.
  - START: drives 0.
  - DATA: 8 bits, LSB first.
  - STOP: drives 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between STOP and the next START.
- RX path:
  - uart_rx passes through a 2-flop synchronizer. All logic uses the synchronized signal.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized low enters START and resets the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, re-sample. If high, this is a false start: return to IDLE with no push.
  - DATA: sample every CLKS_PER_BIT cycles from mid-start, i.e. at bit centres. Shift in LSB first.
  - STOP: sample at the centre.
    - If 1: push the byte. If the FIFO is full and there is no simultaneous pop, drop the byte and set overrun_err.
    - If 0: drop the byte, set frame_err, and wait in STOP until the line is high before entering IDLE.
- proc_rx_valid rises the cycle after the push.
- Error flags:
  - Set by their events, cleared by err_clear.
  - If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro SERIAL_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP on both TX and RX.
  - Even parity: the XOR of the 8 data bits.
  - On RX parity mismatch: drop the byte and set an extra sticky output parity_err, cleared like the other flags.
  - Frame is 11 bits.
- Undefined: no PARITY state, no parity_err port, frame is 10 bits.

Decomposition:
- Shared package: UART FSM state encoding (IDLE, START, DATA, PARITY, STOP), frame constants (DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1).
- Natural sub-module: byte_fifo (parameterised depth, FWFT, push/pop/full/empty). It is instantiated twice.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- TX single byte: write 0xA5.
  - uart_tx goes low 2 cycles later for 4 cycles.
  - Then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4.
  - proc_tx_ready stays 1.
- TX fill: write 6 bytes on consecutive cycles.
  - Bytes 1–5 are accepted; proc_tx_ready=0 on the 6th cycle, so byte 6 is ignored.
  - Exactly 5 frames are emitted, with 1 idle cycle between frames.
- RX byte: drive a 0x3C frame.
  - proc_rx_valid=1 and proc_rx_data=0x3C within 4 cycles after the stop-bit centre.
  - rden pulse → proc_rx_valid=0.
- RX errors:
  - A stop bit of 0 → no push, frame_err=1. err_clear → frame_err=0.
  - A low glitch of 1 cycle → no push, no flag.
- RX overrun: send 5 frames with no rden.
  - The first 4 bytes are retained in order; the 5th is dropped; overrun_err=1.
- Reset mid-TX frame: assert reset during DATA.
  - uart_tx=1 the next cycle and stays 1.
  - The FIFO is empty and proc_tx_ready=1.
